// File: rtl/auth_uart_rx.sv
// auth_uart_rx: 8N1 UART receiver driving the 'G'/'S' power authorization FSM.
// Define AUTH_TIMEOUT_EN to add the PWR1 link-loss timeout (TIMEOUT_CYC).
module auth_uart_rx #(
  parameter int BAUD_DIV = 5208
`ifdef AUTH_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 2**24
`endif
) (
  input  logic       clk,
  input  logic       RST_n,
  input  logic       RX,
  input  logic       rider_off,
  output logic       pwr_up,
  output logic [7:0] last_cmd,
  output logic       frame_err
);
  localparam int CW = $clog2(BAUD_DIV) + 1;
  localparam logic [1:0] IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3;
  localparam logic [1:0] OFF = 2'd0, PWR1 = 2'd1, PWR2 = 2'd2;
  logic [2:0] rx_q;
  logic [1:0] rx_st, auth_st, auth_nxt;
  logic [CW-1:0] cnt;
  logic [2:0] bitn;
  logic [7:0] shift;
  logic rx_s, tick, rx_rdy, is_g, is_s, to_hit;
  // rx_q[1] is the synchronized line, rx_q[2] its previous value for edge detection
  assign rx_s   = rx_q[1];
  assign tick   = cnt == '0;
  assign rx_rdy = rx_st == STOP && tick && rx_s;
  assign is_g   = rx_rdy && shift == 8'h47;
  assign is_s   = rx_rdy && shift == 8'h53;
  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      rx_q      <= 3'b111;
      rx_st     <= IDLE;
      cnt       <= '0;
      bitn      <= '0;
      shift     <= '0;
      frame_err <= 1'b0;
      last_cmd  <= 8'h00;
    end else begin
      rx_q      <= {rx_q[1:0], RX};
      frame_err <= rx_st == STOP && tick && !rx_s;
      if (rx_rdy) last_cmd <= shift;
      case (rx_st)
        IDLE: if (rx_q[2] && !rx_s) begin
          rx_st <= START;
          cnt   <= CW'(BAUD_DIV / 2 - 1);
        end
        START: if (!tick) cnt <= cnt - 1'b1;
          else if (rx_s) rx_st <= IDLE;
          else begin
            rx_st <= DATA;
            cnt   <= CW'(BAUD_DIV - 1);
            bitn  <= '0;
          end
        DATA: if (!tick) cnt <= cnt - 1'b1;
          else begin
            shift <= {rx_s, shift[7:1]};
            cnt   <= CW'(BAUD_DIV - 1);
            bitn  <= bitn + 1'b1;
            if (bitn == 3'd7) rx_st <= STOP;
          end
        default: if (!tick) cnt <= cnt - 1'b1;
          else rx_st <= IDLE;
      endcase
    end
  end
`ifdef AUTH_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC) + 1;
  logic [TW-1:0] tcnt;
  assign to_hit = auth_st == PWR1 && tcnt == TW'(TIMEOUT_CYC - 1);
  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) tcnt <= '0;
    else tcnt <= (auth_st != PWR1 || rx_rdy || to_hit) ? '0 : tcnt + 1'b1;
  end
`else
  assign to_hit = 1'b0;
`endif
  // a 'G' in PWR2 outranks a simultaneous rider_off
  always_comb
    auth_nxt = auth_st == OFF  ? (is_g ? PWR1 : OFF) :
               auth_st == PWR1 ? (is_s ? (rider_off ? OFF : PWR2) : to_hit ? PWR2 : PWR1) :
                                 (is_g ? PWR1 : rider_off ? OFF : PWR2);
  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      auth_st <= OFF;
      pwr_up  <= 1'b0;
    end else begin
      auth_st <= auth_nxt;
      pwr_up  <= auth_nxt != OFF;
    end
  end
endmodule

// File: tb/tb_auth_uart_rx.sv
// tb_auth_uart_rx: scoreboard bench with a behavioural authorization model, BAUD_DIV=16.
module tb_auth_uart_rx;
  localparam int BD = 16;
  logic clk = 1'b0, RST_n = 1'b0, RX = 1'b1, rider_off = 1'b0;
  logic pwr_up, frame_err;
  logic [7:0] last_cmd;
  always #5 clk = ~clk;
  auth_uart_rx #(
    .BAUD_DIV(BD)
`ifdef AUTH_TIMEOUT_EN
    , .TIMEOUT_CYC(1000)
`endif
  ) dut (
    .clk(clk), .RST_n(RST_n), .RX(RX), .rider_off(rider_off),
    .pwr_up(pwr_up), .last_cmd(last_cmd), .frame_err(frame_err)
  );
  typedef struct packed {logic err; logic [7:0] cmd; logic pwr;} exp_t;
  exp_t q[$];
  int total = 0, passed = 0;
  int st = 0;
  logic [7:0] m_cmd = 8'h00;
  function automatic int nxt(int s, logic [7:0] b, logic ro);
    if (s == 0) return b == 8'h47 ? 1 : 0;
    if (s == 1) return b == 8'h53 ? (ro ? 0 : 2) : 1;
    return b == 8'h47 ? 1 : (ro ? 0 : 2);
  endfunction
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  task automatic drive_bits(logic [9:0] frame, int nbits);
    for (int i = 0; i < nbits; i++) begin
      RX = frame[i];
      repeat (BD) @(negedge clk);
    end
    RX = 1'b1;
  endtask
  task automatic send(logic [7:0] b, logic stop_ok);
    exp_t e;
    if (stop_ok) begin
      st = nxt(st, b, rider_off);
      m_cmd = b;
    end
    e.err = !stop_ok;
    e.cmd = m_cmd;
    e.pwr = st != 0;
    q.push_back(e);
    drive_bits({stop_ok, b, 1'b0}, 10);
    repeat (4) @(negedge clk);
  endtask
  task automatic set_ro(logic v);
    rider_off = v;
    if (v && st == 2) st = 0;
    repeat (2) @(negedge clk);
    check("pwr_up_after_rider_off", pwr_up, st != 0);
  endtask
  initial begin : monitor
    exp_t e;
    logic is_err;
    forever begin
      @(negedge clk);
      if (dut.rx_rdy || frame_err) begin
        is_err = frame_err;
        if (!is_err) @(negedge clk);
        if (q.size() == 0) begin
          total++;
          $display("FAIL unexpected_output: frame_err=%0b last_cmd=%0h with no frame pending", is_err, last_cmd);
        end else begin
          e = q.pop_front();
          check("frame_err_kind", frame_err, e.err);
          check("last_cmd", last_cmd, e.cmd);
          check("pwr_up", pwr_up, e.pwr);
          if (is_err) begin
            @(negedge clk);
            check("frame_err_one_cycle", frame_err, 0);
          end
        end
      end
    end
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
  initial begin
    repeat (5) @(negedge clk);
    check("reset_pwr_up", pwr_up, 0);
    check("reset_last_cmd", last_cmd, 8'h00);
    check("reset_frame_err", frame_err, 0);
    RST_n = 1'b1;
    repeat (5) @(negedge clk);
    check("post_reset_pwr_up", pwr_up, 0);
    check("post_reset_last_cmd", last_cmd, 8'h00);
    fork
      send(8'h47, 1'b1);
      begin
        int n = 0;
        while (!pwr_up && n < 200) begin
          @(negedge clk);
          n++;
        end
        check("g_latency_within_160", n <= 160, 1);
      end
    join
    send(8'h53, 1'b1);
    set_ro(1'b1);
    send(8'h53, 1'b1);
    set_ro(1'b0);
    send(8'h47, 1'b1);
    set_ro(1'b1);
    send(8'h53, 1'b1);
    send(8'h41, 1'b1);
    set_ro(1'b0);
    send(8'h47, 1'b0);
    RX = 1'b0;
    repeat (4) @(negedge clk);
    RX = 1'b1;
    repeat (40) @(negedge clk);
    drive_bits({1'b1, 8'h47, 1'b0}, 4);
    RX = 1'b0;
    repeat (5) @(negedge clk);
    RST_n = 1'b0;
    RX = 1'b1;
    st = 0;
    m_cmd = 8'h00;
    repeat (3) @(negedge clk);
    check("midbyte_reset_pwr_up", pwr_up, 0);
    check("midbyte_reset_last_cmd", last_cmd, 8'h00);
    RST_n = 1'b1;
    repeat (5) @(negedge clk);
    send(8'h47, 1'b1);
`ifdef AUTH_TIMEOUT_EN
    repeat (1100) @(negedge clk);
    check("timeout_keeps_pwr_up", pwr_up, 1);
    st = 2;
    set_ro(1'b1);
`else
    repeat (5000) @(negedge clk);
    check("no_timeout_pwr_up", pwr_up, 1);
    set_ro(1'b1);
`endif
    set_ro(1'b0);
    for (int i = 0; i < 40; i++) begin
      logic [7:0] b;
      logic ok;
      int k = $urandom_range(0, 3);
      b = k == 0 ? 8'h47 : k == 1 ? 8'h53 : 8'($urandom);
      ok = 1'b1;
`ifndef AUTH_TIMEOUT_EN
      ok = $urandom_range(0, 7) != 0;
`endif
      if ($urandom_range(0, 3) == 0) set_ro(1'($urandom));
      send(b, ok);
      repeat ($urandom_range(0, 40)) @(negedge clk);
    end
    repeat (20) @(negedge clk);
    check("scoreboard_drained", q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
